// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with ready/valid word output
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.

module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  logic [1:0]           sync_q, sync_d;
  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rx_s;
  logic                 ferr_now;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic perr_acc_q, perr_acc_d;
  logic perr_q, perr_d;
`else
  // Parity sense only matters when parity checking is compiled in.
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // Two-stage synchroniser on the asynchronous line; bit 0 is the first stage.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // Synchroniser flops, resetting to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Frame FSM plus output register next-state; the FSM moves only on sample ticks.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = valid_q && !ready;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    ferr_now   = ferr_acc_q || !rx_s;
`ifdef UART_RX_PARITY_EN
    perr_acc_d = perr_acc_q;
    perr_d     = 1'b0;
`endif
    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            tick_d  = '0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick_q == HALF_LAST) begin
            tick_d     = '0;
            bit_d      = '0;
            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_d = 1'b0;
`endif
            // A line that is high again at mid start bit was a glitch.
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            perr_acc_d = (^shift_q) ^ rx_s ^ PAR_ODD;
            state_d    = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bit_q == STOP_LAST) begin
              // Frame complete: publish the word and its status on this edge.
              bit_d   = '0;
              state_d = ST_IDLE;
              data_d  = shift_q;
              valid_d = 1'b1;
              ferr_d  = ferr_now;
              ovr_d   = valid_q && !ready;
`ifdef UART_RX_PARITY_EN
              perr_d  = perr_acc_q;
`endif
            end else begin
              bit_d      = bit_q + 1'b1;
              ferr_acc_d = ferr_now;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_acc_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_acc_q <= perr_acc_d;
      perr_q     <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule
